// File: rtl/mac_tap_sequencer_pkg.sv
// Shared definitions for the tap sequencer and its MAC engine: FSM state
// encoding and the width helpers derived from the data and tap-count parameters.
package mac_tap_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Result width: full product of two operands plus one carry bit.
  function automatic int res_w(input int szin);
    return 2 * (szin + 1) + 1;
  endfunction

  // Coefficient address width, never narrower than one bit.
  function automatic int addr_w(input int szn);
    return (szn <= 2) ? 1 : $clog2(szn);
  endfunction

endpackage

// File: rtl/mac_tap_sequencer_if.sv
// Bus bundle between the tap sequencer and its environment (sample source,
// coefficient writer, MAC engine, output sink).
//
// Handshakes: a sample moves on every rising edge where s_vld and s_rdy are
// both high; the output moves on every edge where y_vld and y_rdy are both
// high. A source holds valid and its payload until the transfer happens;
// ready may be high before valid arrives. mac_vld is a one-way strobe: the
// MAC accumulates on each edge where it is high, with no back-pressure.
interface mac_tap_sequencer_if
  import mac_tap_sequencer_pkg::*;
#(
  parameter int SZin = 7,
  parameter int SZN  = 3
);

  localparam int W     = SZin + 1;
  localparam int RES_W = res_w(SZin);
  localparam int AW    = addr_w(SZN);

  logic [W-1:0]     s_data;
  logic             s_vld;
  logic             s_rdy;
  logic             coef_we;
  logic [AW-1:0]    coef_addr;
  logic [W-1:0]     coef_wdata;
  logic [W-1:0]     mac_a;
  logic [W-1:0]     mac_x;
  logic             mac_vld;
  logic             mac_first;
  logic [RES_W-1:0] mac_res;
  logic [RES_W-1:0] y_data;
  logic             y_vld;
  logic             y_rdy;
  state_e           dbg_state;

  modport slave (
    input  s_data, s_vld, coef_we, coef_addr, coef_wdata, mac_res, y_rdy,
    output s_rdy, mac_a, mac_x, mac_vld, mac_first, y_data, y_vld, dbg_state
  );

  modport master (
    output s_data, s_vld, coef_we, coef_addr, coef_wdata, mac_res, y_rdy,
    input  s_rdy, mac_a, mac_x, mac_vld, mac_first, y_data, y_vld, dbg_state
  );

endinterface

// File: rtl/mac_tap_sequencer_tap_delay_line.sv
// Sample history: N-deep shift register, newest sample in slot 0.
module mac_tap_sequencer_tap_delay_line #(
  parameter int W = 8,
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en_i,
  input  logic [W-1:0]        din_i,
  output logic [N-1:0][W-1:0] taps_o
);

  logic [N-1:0][W-1:0] taps_q, taps_d;

  // Next history: push the new sample in at slot 0 when enabled.
  always_comb begin
    taps_d = taps_q;
    if (shift_en_i) begin
      taps_d[0] = din_i;
      for (int k = 1; k < N; k++) begin
        taps_d[k] = taps_q[k-1];
      end
    end
  end

  // History register, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) taps_q <= '0;
    else      taps_q <= taps_d;
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/mac_tap_sequencer.sv
// FIR initiator: accepts a sample, issues one (coef, sample) pair per tap to
// an external MAC, captures the final sum and offers it as the filter output.
module mac_tap_sequencer
  import mac_tap_sequencer_pkg::*;
#(
  parameter int SZin = 7,
  parameter int SZN  = 3
) (
  input  logic               clk,
  input  logic               rst,
  mac_tap_sequencer_if.slave bus
);

  localparam int W     = SZin + 1;
  localparam int RES_W = res_w(SZin);
  localparam int AW    = addr_w(SZN);
  localparam logic [AW-1:0] CNT_LAST = AW'(SZN - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [RES_W-1:0]    y_q, y_d;
  logic [W-1:0]        coef_q [SZN];
  logic [W-1:0]        coef_d [SZN];
  logic                shift_en;
  logic                in_run;
  logic [SZN-1:0][W-1:0] taps;

  mac_tap_sequencer_tap_delay_line #(
    .W (W),
    .N (SZN)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .din_i      (bus.s_data),
    .taps_o     (taps)
  );

  // Coefficient file update: out-of-range addresses are dropped, and the
  // new value only becomes visible to the tap stream on the next cycle.
  always_comb begin
    coef_d = coef_q;
    if (bus.coef_we && (int'(bus.coef_addr) < SZN)) begin
      coef_d[bus.coef_addr] = bus.coef_wdata;
    end
  end

  // FSM next state, tap counter and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.s_vld) begin
          shift_en = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // MAC result is registered, so the last pair's sum is visible now.
        y_d     = bus.mac_res;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.y_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, result and coefficient registers; reset aborts any
  // operation in flight and clears the coefficients.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      for (int i = 0; i < SZN; i++) coef_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      coef_q  <= coef_d;
    end
  end

  // Outputs decoded from registers only; s_rdy is also held low during reset.
  assign in_run        = (state_q == ST_RUN);
  assign bus.s_rdy     = rst && (state_q == ST_IDLE);
  assign bus.mac_vld   = in_run;
  assign bus.mac_first = in_run && (cnt_q == '0);
  assign bus.mac_a     = in_run ? coef_q[cnt_q] : '0;
  assign bus.mac_x     = in_run ? taps[cnt_q] : '0;
  assign bus.y_vld     = (state_q == ST_OUT);
  assign bus.y_data    = y_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Bench for mac_tap_sequencer with SZin=3, SZN=3 and a behavioural MAC.
module tb_mac_tap_sequencer;
  import mac_tap_sequencer_pkg::*;

  localparam int SZIN = 3;
  localparam int SZN  = 3;
  localparam int W    = 4;
  localparam int RW   = 9;
  localparam int TO   = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [RW-1:0] mac_res_q = '0;
  logic [W-1:0]  coef_m [SZN];
  logic [W-1:0]  hist_m [SZN];
  logic [RW-1:0] exp_q [$];

  mac_tap_sequencer_if #(.SZin(SZIN), .SZN(SZN)) bus ();

  mac_tap_sequencer #(.SZin(SZIN), .SZN(SZN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / MAC engine model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mac_vld)
      mac_res_q <= bus.mac_first ? (RW'(bus.mac_a) * RW'(bus.mac_x))
                                 : (mac_res_q + RW'(bus.mac_a) * RW'(bus.mac_x));
  end
  assign bus.mac_res = mac_res_q;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic void m_clear();
    for (int k = 0; k < SZN; k++) begin
      coef_m[k] = '0;
      hist_m[k] = '0;
    end
  endfunction

  function automatic void m_write(input int a, input logic [W-1:0] v);
    if (a < SZN) coef_m[a] = v;
  endfunction

  function automatic void m_push(input logic [W-1:0] d);
    for (int k = SZN - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = d;
  endfunction

  // FIR output: sum of coef*history over all taps, wrapped to RW bits.
  function automatic logic [RW-1:0] m_y();
    int s = 0;
    for (int k = 0; k < SZN; k++) s += int'(coef_m[k]) * int'(hist_m[k]);
    return RW'(s % (1 << RW));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input logic [W-1:0] v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 2'(a);
    bus.coef_wdata = v;
    step();
    bus.coef_we = 1'b0;
    m_write(a, v);
  endtask

  // Returns one cycle after the accepting edge (first RUN cycle).
  task automatic send_sample(input logic [W-1:0] d, output bit ok);
    int n = 0;
    bus.s_data = d;
    bus.s_vld  = 1'b1;
    while (!bus.s_rdy && n < TO) begin
      step();
      n++;
    end
    ok = bus.s_rdy;
    step();
    bus.s_vld = 1'b0;
    if (ok) m_push(d);
  endtask

  // Latency counted with the first RUN cycle as 1; -1 on timeout.
  task automatic wait_y(output int lat, output logic [RW-1:0] y);
    int n = 1;
    while (!bus.y_vld && n < TO) begin
      step();
      n++;
    end
    lat = bus.y_vld ? n : -1;
    y   = bus.y_data;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.s_data = '0; bus.s_vld = 1'b0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_wdata = '0; bus.y_rdy = 1'b1;
    rst = 1'b0;
    m_clear();
    step();
    step();
    checks++;
    if (bus.s_rdy !== 1'b0 || bus.mac_vld !== 1'b0 || bus.y_vld !== 1'b0 || bus.mac_first !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: s_rdy=%b mac_vld=%b y_vld=%b mac_first=%b expected all 0",
               bus.s_rdy, bus.mac_vld, bus.y_vld, bus.mac_first);
    end
    checks++;
    if (bus.y_data !== '0 || bus.mac_a !== '0 || bus.mac_x !== '0) begin
      failures++;
      $display("FAIL reset_data: y_data=%0d mac_a=%0d mac_x=%0d expected 0", bus.y_data, bus.mac_a, bus.mac_x);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.s_rdy !== 1'b1 || bus.dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_release: s_rdy=%b state=%0d expected 1 and IDLE", bus.s_rdy, bus.dbg_state);
    end
    step();
  endtask

  task automatic test_basic();
    logic [RW-1:0] y;
    logic [RW-1:0] fixed_y [3];
    int lat;
    bit ok;
    fixed_y[0] = 9'd1; fixed_y[1] = 9'd4; fixed_y[2] = 9'd10;
    write_coef(0, 4'd1);
    write_coef(1, 4'd2);
    write_coef(2, 4'd3);
    for (int i = 0; i < 3; i++) begin
      send_sample(W'(i + 1), ok);
      wait_y(lat, y);
      checks++;
      if (!ok || lat !== 5) begin
        failures++;
        $display("FAIL basic_latency[%0d]: got %0d expected 5 (accepted=%0d)", i, lat, ok);
      end
      checks++;
      if (y !== m_y() || y !== fixed_y[i]) begin
        failures++;
        $display("FAIL basic_y[%0d]: got %0d expected %0d", i, y, m_y());
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [RW-1:0] y;
    int lat;
    bit ok;
    for (int k = 0; k < SZN; k++) write_coef(k, 4'd15);
    for (int i = 0; i < 3; i++) begin
      send_sample(4'd15, ok);
      wait_y(lat, y);
      checks++;
      if (y !== m_y()) begin
        failures++;
        $display("FAIL wrap_y[%0d]: got %0d expected %0d", i, y, m_y());
      end
      step();
    end
    checks++;
    if (y !== 9'd163) begin
      failures++;
      $display("FAIL wrap_final: got %0d expected 163", y);
    end
  endtask

  task automatic test_hold_output();
    logic [RW-1:0] y, y0;
    int lat;
    bit ok;
    bus.y_rdy = 1'b0;
    send_sample(W'($urandom_range(15, 1)), ok);
    wait_y(lat, y0);
    checks++;
    if (lat !== 5 || y0 !== m_y()) begin
      failures++;
      $display("FAIL hold_first: y=%0d lat=%0d expected y=%0d lat=5", y0, lat, m_y());
    end
    bus.s_vld  = 1'b1;
    bus.s_data = W'($urandom_range(15, 1));
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.y_vld !== 1'b1 || bus.y_data !== y0 || bus.s_rdy !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable[%0d]: y_vld=%b y_data=%0d s_rdy=%b expected 1/%0d/0",
                 i, bus.y_vld, bus.y_data, bus.s_rdy, y0);
      end
    end
    bus.s_vld = 1'b0;
    bus.y_rdy = 1'b1;
    step();
    checks++;
    if (bus.y_vld !== 1'b0 || bus.s_rdy !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: y_vld=%b s_rdy=%b expected 0/1", bus.y_vld, bus.s_rdy);
    end
    send_sample(W'($urandom_range(15, 1)), ok);
    wait_y(lat, y);
    checks++;
    if (y !== m_y()) begin
      failures++;
      $display("FAIL hold_after: got %0d expected %0d", y, m_y());
    end
    step();
  endtask

  task automatic test_coef_in_run();
    logic [RW-1:0] y, exp_y;
    int lat, n;
    bit ok;
    write_coef(0, 4'd2);
    write_coef(1, 4'd3);
    write_coef(2, 4'd5);
    send_sample(4'd4, ok); wait_y(lat, y); step();
    send_sample(4'd6, ok); wait_y(lat, y); step();
    bus.s_data = 4'd3;
    bus.s_vld  = 1'b1;
    n = 0;
    while (!bus.s_rdy && n < TO) begin step(); n++; end
    step();
    bus.s_vld = 1'b0;
    m_push(4'd3);
    checks++;
    if (bus.mac_vld !== 1'b1 || bus.mac_first !== 1'b1) begin
      failures++;
      $display("FAIL run_tap0: mac_vld=%b mac_first=%b expected 1/1", bus.mac_vld, bus.mac_first);
    end
    bus.coef_we = 1'b1; bus.coef_addr = 2'd2; bus.coef_wdata = 4'd7;
    m_write(2, 4'd7);
    step();
    checks++;
    if (bus.mac_a !== coef_m[1] || bus.mac_first !== 1'b0) begin
      failures++;
      $display("FAIL run_tap1: mac_a=%0d mac_first=%b expected %0d/0", bus.mac_a, bus.mac_first, coef_m[1]);
    end
    bus.coef_addr = 2'd3; bus.coef_wdata = 4'd13;
    m_write(3, 4'd13);
    step();
    checks++;
    if (bus.mac_a !== 4'd7 || bus.mac_x !== hist_m[2]) begin
      failures++;
      $display("FAIL run_tap2: mac_a=%0d mac_x=%0d expected 7/%0d", bus.mac_a, bus.mac_x, hist_m[2]);
    end
    exp_y = m_y();
    bus.coef_addr = 2'd2; bus.coef_wdata = 4'd11;
    step();
    bus.coef_we = 1'b0;
    m_write(2, 4'd11);
    wait_y(lat, y);
    checks++;
    if (lat < 0 || y !== exp_y) begin
      failures++;
      $display("FAIL run_write_y: got %0d expected %0d", y, exp_y);
    end
    step();
    send_sample(4'd1, ok);
    wait_y(lat, y);
    checks++;
    if (y !== m_y()) begin
      failures++;
      $display("FAIL run_write_next: got %0d expected %0d", y, m_y());
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [RW-1:0] y;
    int lat;
    bit ok;
    for (int k = 0; k < SZN; k++) write_coef(k, W'($urandom_range(15, 1)));
    send_sample(4'd9, ok);
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mac_vld !== 1'b0 || bus.mac_first !== 1'b0 || bus.mac_a !== '0 || bus.mac_x !== '0 ||
        bus.s_rdy !== 1'b0 || bus.y_vld !== 1'b0 || bus.y_data !== '0) begin
      failures++;
      $display("FAIL midrun_reset: mac_vld=%b mac_a=%0d mac_x=%0d s_rdy=%b y_vld=%b y_data=%0d expected all 0",
               bus.mac_vld, bus.mac_a, bus.mac_x, bus.s_rdy, bus.y_vld, bus.y_data);
    end
    step();
    step();
    rst = 1'b1;
    m_clear();
    step();
    checks++;
    if (bus.dbg_state !== ST_IDLE || bus.y_vld !== 1'b0) begin
      failures++;
      $display("FAIL midrun_idle: state=%0d y_vld=%b expected IDLE/0", bus.dbg_state, bus.y_vld);
    end
    send_sample(4'd5, ok);
    wait_y(lat, y);
    checks++;
    if (y !== m_y() || y !== '0) begin
      failures++;
      $display("FAIL midrun_zero: got %0d expected 0", y);
    end
    step();
    for (int k = 0; k < SZN; k++) write_coef(k, 4'd1);
    send_sample(4'd2, ok);
    wait_y(lat, y);
    checks++;
    if (y !== m_y()) begin
      failures++;
      $display("FAIL midrun_history: got %0d expected %0d", y, m_y());
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acc_cyc [$];
    int firsts = 0;
    int cyc = 0;
    int sent = 0;
    int nsamp = 5;
    bit acc;
    logic [W-1:0]  cur;
    logic [RW-1:0] e;
    for (int k = 0; k < SZN; k++) write_coef(k, W'($urandom_range(15, 0)));
    bus.y_rdy  = 1'b1;
    cur        = W'($urandom_range(15, 0));
    bus.s_data = cur;
    bus.s_vld  = 1'b1;
    while ((sent < nsamp || exp_q.size() > 0) && cyc < 200) begin
      if (bus.y_vld && bus.y_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: unexpected output %0d", bus.y_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.y_data !== e) begin
            failures++;
            $display("FAIL b2b_y: got %0d expected %0d", bus.y_data, e);
          end
        end
      end
      if (bus.mac_first) firsts++;
      acc = bus.s_vld && bus.s_rdy;
      if (acc) begin
        acc_cyc.push_back(cyc);
        m_push(cur);
        exp_q.push_back(m_y());
        sent++;
      end
      step();
      cyc++;
      if (acc) begin
        if (sent < nsamp) begin
          cur        = W'($urandom_range(15, 0));
          bus.s_data = cur;
        end else begin
          bus.s_vld = 1'b0;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || sent != nsamp) begin
      failures++;
      $display("FAIL b2b_drain: sent=%0d pending=%0d expected %0d/0", sent, exp_q.size(), nsamp);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != SZN + 3) begin
        failures++;
        $display("FAIL b2b_rate[%0d]: got %0d cycles expected %0d", i, acc_cyc[i] - acc_cyc[i-1], SZN + 3);
      end
    end
    checks++;
    if (firsts != nsamp) begin
      failures++;
      $display("FAIL b2b_first: got %0d pulses expected %0d", firsts, nsamp);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold_output();
    test_coef_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
